intr_claim_ctrl: RTL

INTR_CLAIM_CTRL -- requirements
Module: intr_claim_ctrl

---
 rtl/intr_claim_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/intr_claim_ctrl.sv
// Interrupt claim controller: qualifies the winning source, raises cpu_irq,
// tracks ack/eoi handshake, clears the claimed request and flags ack timeouts.
module intr_claim_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       intr_ev,
    input  logic [2:0] intr_id,
    input  logic [2:0] intr_prio,
    input  logic       I_flag,
    input  logic [2:0] prio_threshold,
    input  logic       cpu_ack,
    input  logic       cpu_eoi,
    output logic       cpu_irq,
    output logic [2:0] claim_id,
    output logic       claim_valid,
    output logic [7:0] irq_clr,
    output logic       err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE,
        GAP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [2:0] cand_id, cand_id_nxt;
    logic [2:0] cand_prio, cand_prio_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       irq_nxt;
    logic       cv_nxt;
    logic [2:0] cid_nxt;
    logic [7:0] clr_nxt;
    logic       err_nxt;
    logic       qual;
    logic       withdraw;

    assign qual     = intr_ev & I_flag & (intr_prio > prio_threshold);
    assign withdraw = ~intr_ev | ~I_flag;

    // State, candidate, counter and all outputs are registered together
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= IDLE;
            cand_id     <= 3'd0;
            cand_prio   <= 3'd0;
            cnt         <= 8'd0;
            cpu_irq     <= 1'b0;
            claim_valid <= 1'b0;
            claim_id    <= 3'd0;
            irq_clr     <= 8'h00;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand_id     <= cand_id_nxt;
            cand_prio   <= cand_prio_nxt;
            cnt         <= cnt_nxt;
            cpu_irq     <= irq_nxt;
            claim_valid <= cv_nxt;
            claim_id    <= cid_nxt;
            irq_clr     <= clr_nxt;
            err_timeout <= err_nxt;
        end
    end

    // Next state and next output values; REQ resolves ack > withdraw > timeout > update
    always_comb begin
        state_nxt     = state;
        cand_id_nxt   = cand_id;
        cand_prio_nxt = cand_prio;
        cnt_nxt       = cnt;
        irq_nxt       = cpu_irq;
        cv_nxt        = claim_valid;
        cid_nxt       = claim_id;
        clr_nxt       = 8'h00;
        err_nxt       = err_timeout;
        unique case (state)
            IDLE: begin
                if (qual) begin
                    cand_id_nxt   = intr_id;
                    cand_prio_nxt = intr_prio;
                    cnt_nxt       = 8'd0;
                    irq_nxt       = 1'b1;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                cnt_nxt = cnt + 8'd1;
                if (cpu_ack) begin
                    irq_nxt   = 1'b0;
                    cv_nxt    = 1'b1;
                    cid_nxt   = cand_id;
                    clr_nxt   = 8'd1 << cand_id;
                    state_nxt = SERVICE;
                end else if (withdraw) begin
                    irq_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if (qual && cnt == CNT_LAST) begin
                    irq_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (qual && intr_prio > cand_prio) begin
                    cand_id_nxt   = intr_id;
                    cand_prio_nxt = intr_prio;
                    cnt_nxt       = 8'd0;
                end
            end
            SERVICE: begin
                if (cpu_eoi) begin
                    cv_nxt    = 1'b0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
